// File: rtl/sm4_pkg.sv
// sm4_pkg: SM4 constants, FSM encoding and linear-transform helpers shared by the encrypt and decrypt tops.
package sm4_pkg;

  typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_ROUND, S_DONE} state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  localparam logic [31:0] CK [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] l_enc(input logic [31:0] b);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

endpackage

// File: rtl/sm4_tau.sv
// sm4_tau: nonlinear byte substitution, four S-box lookups on one 32-bit word.
module sm4_tau
  import sm4_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] b
);

  for (genvar i = 0; i < 4; i++) begin : g_sb
    assign b[8*i +: 8] = SBOX[a[8*i +: 8]];
  end

endmodule

// File: rtl/sm4_decrypt.sv
// sm4_decrypt: iterative SM4 decryption, 32 key-expansion cycles then 32 round cycles.
// Define SM4_DEC_KEY_CACHE_EN to skip key expansion when the key matches the last expanded one.
module sm4_decrypt
  import sm4_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [127:0] IN_DATA,
  input  logic [127:0] IN_KEY,
  output logic         BUSY,
  output logic         OUT_READY,
  output logic [127:0] OUT_DATA
);

  localparam logic [127:0] FK_ALL = {FK[0], FK[1], FK[2], FK[3]};

  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [127:0]  k_q, k_d, x_q, x_d, out_q, out_d;
  logic          rdy_q, rdy_d, fin_q, fin_d;
  logic [31:0]   rk_q [32];
  logic [31:0]   tau_a, tau_b, rk_new, x_new;
  logic          accept, hit, last, rk_we;
`ifdef SM4_DEC_KEY_CACHE_EN
  logic          kv_q, kv_d;
  logic [127:0]  tag_q, tag_d;
`endif

  sm4_tau u_tau (.a(tau_a), .b(tau_b));

  // Key window k_q holds K(i)..K(i+3); data window x_q holds X(j)..X(j+3).
  always_comb begin
    accept = START && (state_q == S_IDLE || state_q == S_DONE);
`ifdef SM4_DEC_KEY_CACHE_EN
    hit = kv_q && (IN_KEY == tag_q);
`else
    hit = 1'b0;
`endif
    last = &cnt_q;
    tau_a = (state_q == S_KEYEXP) ? k_q[95:64] ^ k_q[63:32] ^ k_q[31:0] ^ CK[cnt_q]
                                  : x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk_q[~cnt_q];
    rk_new = k_q[127:96] ^ l_key(tau_b);
    x_new = x_q[127:96] ^ l_enc(tau_b);
    state_d = state_q;
    cnt_d = cnt_q;
    k_d = k_q;
    x_d = x_q;
    rk_we = 1'b0;
    fin_d = (state_q == S_ROUND) && last;
    out_d = fin_q ? {x_q[31:0], x_q[63:32], x_q[95:64], x_q[127:96]} : out_q;
    rdy_d = !accept && (fin_q || rdy_q);
    case (state_q)
      S_IDLE, S_DONE: if (accept) begin
        state_d = hit ? S_ROUND : S_KEYEXP;
        cnt_d = 5'd0;
        x_d = IN_DATA;
        k_d = IN_KEY ^ FK_ALL;
      end
      S_KEYEXP: begin
        rk_we = 1'b1;
        k_d = {k_q[95:0], rk_new};
        cnt_d = cnt_q + 5'd1;
        state_d = last ? S_ROUND : S_KEYEXP;
      end
      S_ROUND: begin
        x_d = {x_q[95:0], x_new};
        cnt_d = cnt_q + 5'd1;
        state_d = last ? S_DONE : S_ROUND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      k_q <= '0;
      x_q <= '0;
      out_q <= '0;
      rdy_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      k_q <= k_d;
      x_q <= x_d;
      out_q <= out_d;
      rdy_q <= rdy_d;
      fin_q <= fin_d;
    end
    if (rk_we) rk_q[cnt_q] <= rk_new;
  end

`ifdef SM4_DEC_KEY_CACHE_EN
  // A miss overwrites the key file, so the tag is only trusted once expansion completes.
  always_comb begin
    kv_d = kv_q;
    tag_d = tag_q;
    if (accept && !hit) begin
      kv_d = 1'b0;
      tag_d = IN_KEY;
    end else if (state_q == S_KEYEXP && last) begin
      kv_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) kv_q <= 1'b0;
    else kv_q <= kv_d;
    tag_q <= tag_d;
  end
`endif

  assign BUSY = (state_q == S_KEYEXP) || (state_q == S_ROUND);
  assign OUT_READY = rdy_q;
  assign OUT_DATA = out_q;

endmodule

// File: tb/tb_sm4_decrypt.sv
// tb_sm4_decrypt: scoreboard bench; ciphertexts come from an independent encrypt model in the bench.
module tb_sm4_decrypt;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [127:0] IN_DATA = '0;
  logic [127:0] IN_KEY = '0;
  logic         BUSY, OUT_READY;
  logic [127:0] OUT_DATA;

  int total = 0;
  int bad = 0;
  logic [127:0] exp_q [$];
  bit kv = 1'b0;
  logic [127:0] last_key = '0;

  localparam logic [127:0] KAT_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] KAT_CT  = 128'h681edf34d206965e86b3e94f536e4246;

  localparam logic [7:0] TB_SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  sm4_decrypt dut (
    .CLK(CLK), .RST(RST), .START(START), .IN_DATA(IN_DATA), .IN_KEY(IN_KEY),
    .BUSY(BUSY), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] m_rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] m_t(input logic [31:0] a, input bit key);
    logic [31:0] b;
    for (int j = 0; j < 4; j++) b[8*j +: 8] = TB_SBOX[a[8*j +: 8]];
    return key ? b ^ m_rol(b, 13) ^ m_rol(b, 23)
               : b ^ m_rol(b, 2) ^ m_rol(b, 10) ^ m_rol(b, 18) ^ m_rol(b, 24);
  endfunction

  function automatic logic [127:0] m_enc(input logic [127:0] p, input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] x [36];
    logic [31:0] ck;
    k[0] = mk[127:96] ^ 32'ha3b1bac6;
    k[1] = mk[95:64] ^ 32'h56aa3350;
    k[2] = mk[63:32] ^ 32'h677d9197;
    k[3] = mk[31:0] ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * i) + j) * 7);
      k[i+4] = k[i] ^ m_t(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck, 1'b1);
    end
    x[0] = p[127:96];
    x[1] = p[95:64];
    x[2] = p[63:32];
    x[3] = p[31:0];
    for (int i = 0; i < 32; i++) x[i+4] = x[i] ^ m_t(x[i+1] ^ x[i+2] ^ x[i+3] ^ k[i+4], 1'b0);
    return {x[35], x[34], x[33], x[32]};
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [127:0] key);
`ifdef SM4_DEC_KEY_CACHE_EN
    return (kv && key == last_key) ? 33 : 65;
`else
    return 65;
`endif
  endfunction

  // Drives one decrypt; optional stray START pulses at cycles 10 and 50 must be ignored.
  task automatic run_op(input logic [127:0] ct, input logic [127:0] pt, input logic [127:0] key, input bit noise);
    int lat, n;
    bit seen;
    lat = exp_lat(key);
    exp_q.push_back(pt);
    @(negedge CLK);
    START = 1'b1;
    IN_DATA = ct;
    IN_KEY = key;
    @(posedge CLK);
    #1;
    START = 1'b0;
    IN_DATA = r128();
    check("rdy_drop", {127'd0, OUT_READY}, 128'd0);
    check("busy", {127'd0, BUSY}, 128'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge CLK);
      n++;
      #1;
      START = 1'b0;
      if (OUT_READY) seen = 1'b1;
      else if (noise && (n == 10 || n == 50)) begin
        START = 1'b1;
        IN_DATA = r128();
        IN_KEY = r128();
      end
    end
    check("latency", 128'(n), 128'(lat));
    check("plain", OUT_DATA, exp_q.pop_front());
    kv = 1'b1;
    last_key = key;
  endtask

  initial begin
    logic [127:0] pt, kr;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", {127'd0, BUSY}, 128'd0);
    check("rst_rdy", {127'd0, OUT_READY}, 128'd0);
    check("rst_out", OUT_DATA, 128'd0);
    @(negedge CLK);
    RST = 1'b0;

    run_op(KAT_CT, KAT_KEY, KAT_KEY, 1'b0);
    repeat (5) @(posedge CLK);
    #1;
    check("hold_rdy", {127'd0, OUT_READY}, 128'd1);
    check("hold_out", OUT_DATA, KAT_KEY);

    // Abort in the round phase: everything observable clears on the next edge.
    @(negedge CLK);
    START = 1'b1;
    IN_DATA = KAT_CT;
    IN_KEY = KAT_KEY;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (39) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_busy", {127'd0, BUSY}, 128'd0);
    check("abort_rdy", {127'd0, OUT_READY}, 128'd0);
    check("abort_out", OUT_DATA, 128'd0);
    @(negedge CLK);
    RST = 1'b0;
    kv = 1'b0;

    run_op(KAT_CT, KAT_KEY, KAT_KEY, 1'b0);
    pt = r128();
    run_op(m_enc(pt, KAT_KEY), pt, KAT_KEY, 1'b0);
    pt = r128();
    run_op(m_enc(pt, KAT_KEY), pt, KAT_KEY, 1'b1);
    kr = r128();
    pt = r128();
    run_op(m_enc(pt, kr), pt, kr, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || i == 2) kr = r128();
      pt = r128();
      run_op(m_enc(pt, kr), pt, kr, 1'b0);
    end

    // START coincident with RST must not launch an operation.
    @(negedge CLK);
    RST = 1'b1;
    START = 1'b1;
    IN_DATA = KAT_CT;
    IN_KEY = KAT_KEY;
    @(posedge CLK);
    #1;
    check("rs_rdy", {127'd0, OUT_READY}, 128'd0);
    @(negedge CLK);
    RST = 1'b0;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rs_busy", {127'd0, BUSY}, 128'd0);
    check("rs_out", OUT_DATA, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm4_decrypt.md
SM4_DECRYPT -- requirements
Module: sm4_decrypt

Interface
REQ-001 The block SHALL have no parameters; all sizes are fixed by the SM4 standard.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request to decrypt IN_DATA under IN_KEY; honoured only in IDLE or DONE.
REQ-005 IN_DATA  input  128  ciphertext, word X0 = bits 127:96.
REQ-006 IN_KEY  input  128  user key MK, MK0 = bits 127:96.
REQ-007 BUSY  output  1  high while in KEYEXP or ROUND.
REQ-008 OUT_READY  output  1  high while OUT_DATA holds a valid plaintext.
REQ-009 OUT_DATA  output  128  plaintext, reverse-transformed (X35,X34,X33,X32).

Function
REQ-010 The FSM SHALL have states IDLE, KEYEXP, ROUND, DONE.
REQ-011 START high in IDLE or DONE SHALL latch IN_DATA and IN_KEY, clear OUT_READY, and enter KEYEXP next cycle; IN_DATA/IN_KEY are ignored at all other times.
REQ-012 START during KEYEXP or ROUND SHALL be ignored with no effect on the operation in progress.
REQ-013 KEYEXP SHALL compute one round key per cycle, K = MK xor FK, rk[i] = K(i) xor T'(K(i+1) xor K(i+2) xor K(i+3) xor CK[i]), storing rk[0..31] in a 32x32 register file over exactly 32 cycles.
REQ-014 ROUND SHALL perform one round per cycle for 32 cycles, round j using rk[31-j] with T = L(tau(.)), L(B) = B xor B<<<2 xor B<<<10 xor B<<<18 xor B<<<24.
REQ-015 T' SHALL use L'(B) = B xor B<<<13 xor B<<<23.
REQ-016 Round/key counter SHALL be 5 bits, wrap 31->0 marking the phase transition; no other wrap is legal.
REQ-017 Latency: START accepted at edge 0 -> OUT_READY high and OUT_DATA valid after edge 65 (64 cycles compute + 1 output register).
REQ-018 In DONE, OUT_READY and OUT_DATA SHALL hold until the next accepted START or RST.
REQ-019 START accepted in DONE SHALL deassert OUT_READY on the next edge; OUT_DATA may hold stale data while OUT_READY is low.

Reset
REQ-020 RST high SHALL force IDLE, BUSY=0, OUT_READY=0, OUT_DATA=0, counter=0 on the next edge, including mid-KEYEXP or mid-ROUND; the partial result is discarded.
REQ-021 START coincident with RST SHALL be ignored.
REQ-022 The round-key file need not be reset; its content is invalid after reset (and the key-cache tag invalidated under REQ-023).

Configuration
REQ-023 Macro SM4_DEC_KEY_CACHE_EN defined: a valid flag and 128-bit tag of the last fully expanded key SHALL be kept; on accepted START with IN_KEY equal to tag and valid=1, KEYEXP is skipped and ROUND entered directly, latency 33 edges; valid cleared on RST or on abort of KEYEXP.
REQ-024 Macro undefined: every START performs full KEYEXP, latency always 65; no tag/valid storage.

Structure
REQ-025 Shared package sm4_pkg SHALL hold SBOX table, FK[0..3], CK[0..31], the FSM state encoding, and rotate/L/L' functions, shared with the encrypt top.
REQ-026 One sub-module sm4_tau SHALL implement four parallel S-box lookups on a 32-bit word; instantiated once, time-shared between KEYEXP and ROUND.

Verification
REQ-027 Key=0123456789abcdeffedcba9876543210, data=681edf34d206965e86b3e94f536e4246, START one cycle -> OUT_READY after 65 edges, OUT_DATA=0123456789abcdeffedcba9876543210.
REQ-028 RST asserted at cycle 40 of scenario REQ-027 -> next edge BUSY=0, OUT_READY=0, OUT_DATA=0; rerun gives correct plaintext.
REQ-029 START pulses at cycles 10 and 50 during an operation with differing IN_DATA -> ignored, result unchanged, latency 65.
REQ-030 Back-to-back: START in DONE with data from an encrypt-top output -> OUT_READY drops next edge, rises 65 edges later with the original plaintext.
REQ-031 With SM4_DEC_KEY_CACHE_EN: second START with same key -> latency 33, correct plaintext; changed key -> latency 65; without macro both 65.
